// File: rtl/stream_downsize_if.sv
// stream_downsize_if: wide-in / narrow-out stream bundle.
// slave is the downsizer side, master is the driver/sink side.
interface stream_downsize_if #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
);
    logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] s_keep_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i,
        output s_ready_o,
        output m_data_o, m_last_o, m_valid_o,
        input  m_ready_i
    );

    modport master (
        output s_data_i, s_keep_i, s_last_i, s_valid_i,
        input  s_ready_o,
        input  m_data_o, m_last_o, m_valid_o,
        output m_ready_i
    );
endinterface

// File: rtl/stream_downsize.sv
// stream_downsize: splits one wide word into kept narrow lanes,
// lowest lane first, one beat per cycle, no bubble between words.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input logic               clk,
    input logic               rst_n,
    stream_downsize_if.slave  bus
);
    localparam int W  = T_DATA_WIDTH;
    localparam int R  = T_DATA_RATIO;
    localparam int LW = (R > 1) ? $clog2(R) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [R-1:0] ONE = R'(1);

    logic [0:0]   state_q, state_d;
    logic [W-1:0] data_q [R-1:0];
    logic [W-1:0] data_d [R-1:0];
    logic [R-1:0] rem_q, rem_d;
    logic         last_q, last_d;

    logic [LW-1:0] lane;
    logic [R-1:0]  low_bit;
    logic          single;
    logic          accept;
    logic          xfer;
    logic          sending;

    assign low_bit = rem_q & (~rem_q + ONE);
    assign single  = (rem_q != '0) && ((rem_q & (rem_q - ONE)) == '0);
    assign sending = rst_n && (state_q == SEND);

    // Index of the lowest pending lane.
    always_comb begin
        lane = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                lane = LW'(i);
            end
        end
    end

    assign bus.m_valid_o = sending;
    assign bus.m_data_o  = sending ? data_q[lane] : '0;
    assign bus.m_last_o  = sending && last_q && single;

    // Ready in IDLE, or on the final lane when it drains this cycle.
    always_comb begin
        bus.s_ready_o = 1'b0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                bus.s_ready_o = 1'b1;
            end else begin
                bus.s_ready_o = bus.m_ready_i && single;
            end
        end
    end

    assign accept = bus.s_valid_i && bus.s_ready_o;
    assign xfer   = sending && bus.m_ready_i;

    // Drain the current lane; a new word overrides the final clear.
    always_comb begin
        data_d = data_q;
        rem_d  = rem_q;
        last_d = last_q;
        if (xfer) begin
            rem_d = rem_q & ~low_bit;
        end
        if (accept) begin
            data_d = bus.s_data_i;
            rem_d  = bus.s_keep_i;
            last_d = bus.s_last_i;
        end
        state_d = (rem_d != '0) ? SEND : IDLE;
    end

    // Word holding registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '{default: '0};
            rem_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_stream_downsize.sv
// tb_stream_downsize: directed checks of the downsizer
// for ratio 2 and ratio 4 instances.
module tb_stream_downsize;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    stream_downsize_if #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) b2 ();
    stream_downsize_if #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) b4 ();

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2.slave)
    );

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic put2(input logic [3:0] d0, input logic [3:0] d1,
                        input logic [1:0] k, input logic l,
                        input logic v);
        b2.s_data_i[0] = d0;
        b2.s_data_i[1] = d1;
        b2.s_keep_i    = k;
        b2.s_last_i    = l;
        b2.s_valid_i   = v;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        put2(4'h5, 4'h6, 2'b11, 1'b1, 1'b1);
        b2.m_ready_i = 1'b1;
        step;
        #1;
        total++;
        if (b2.s_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_ready got=%b want=0", b2.s_ready_o);
        end
        total++;
        if (b2.m_valid_o !== 1'b0 || b2.m_last_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mvalid got=%b/%b want=0/0",
                     b2.m_valid_o, b2.m_last_o);
        end
        step;
        rst_n = 1'b1;
        put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        #1;
        total++;
        if (b2.s_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_ready got=%b want=1", b2.s_ready_o);
        end
        total++;
        if (b2.m_valid_o !== 1'b0 || b2.m_data_o !== 4'h0) begin
            bad++;
            $display("FAIL post_rst_out got=%b/%h want=0/0",
                     b2.m_valid_o, b2.m_data_o);
        end
        total++;
        if (b4.s_ready_o !== 1'b1 || b4.m_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_r4 got=%b/%b want=1/0",
                     b4.s_ready_o, b4.m_valid_o);
        end
    endtask

    task automatic test_single;
        step;
        put2(4'hA, 4'hB, 2'b11, 1'b1, 1'b1);
        b2.m_ready_i = 1'b1;
        #1;
        total++;
        if (b2.s_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL single_idle_ready got=%b want=1", b2.s_ready_o);
        end
        step;
        put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        #1;
        total++;
        if (b2.m_valid_o !== 1'b1 || b2.m_data_o !== 4'hA ||
            b2.m_last_o !== 1'b0) begin
            bad++;
            $display("FAIL single_beat0 got=%b/%h/%b want=1/a/0",
                     b2.m_valid_o, b2.m_data_o, b2.m_last_o);
        end
        step;
        #1;
        total++;
        if (b2.m_valid_o !== 1'b1 || b2.m_data_o !== 4'hB ||
            b2.m_last_o !== 1'b1) begin
            bad++;
            $display("FAIL single_beat1 got=%b/%h/%b want=1/b/1",
                     b2.m_valid_o, b2.m_data_o, b2.m_last_o);
        end
        step;
        #1;
        total++;
        if (b2.m_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_end got=%b want=0", b2.m_valid_o);
        end
    endtask

    task automatic test_back_to_back;
        b2.m_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            int w;
            logic [3:0] ed;
            step;
            w = (c + 1) / 2;
            if (w < 3) begin
                put2(4'(2 * w + 1), 4'(2 * w + 2), 2'b11, w == 2, 1'b1);
            end else begin
                put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
            end
            #1;
            ed = 4'(c);
            if (c >= 1 && c <= 6) begin
                total++;
                if (b2.m_valid_o !== 1'b1 || b2.m_data_o !== ed ||
                    b2.m_last_o !== (c == 6)) begin
                    bad++;
                    $display("FAIL b2b_beat%0d got=%b/%h/%b want=1/%h/%b",
                             c, b2.m_valid_o, b2.m_data_o, b2.m_last_o,
                             ed, c == 6);
                end
                total++;
                if (b2.s_ready_o !== (c % 2 == 0)) begin
                    bad++;
                    $display("FAIL b2b_ready%0d got=%b want=%b",
                             c, b2.s_ready_o, c % 2 == 0);
                end
            end
            if (c == 7) begin
                total++;
                if (b2.m_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_end got=%b want=0", b2.m_valid_o);
                end
            end
        end
    endtask

    task automatic test_keep;
        b2.m_ready_i = 1'b1;
        step;
        put2(4'hA, 4'hB, 2'b10, 1'b1, 1'b1);
        step;
        put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        #1;
        total++;
        if (b2.m_valid_o !== 1'b1 || b2.m_data_o !== 4'hB ||
            b2.m_last_o !== 1'b1 || b2.s_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL keep10 got=%b/%h/%b/%b want=1/b/1/1",
                     b2.m_valid_o, b2.m_data_o, b2.m_last_o, b2.s_ready_o);
        end
        step;
        put2(4'h7, 4'h8, 2'b00, 1'b1, 1'b1);
        #1;
        total++;
        if (b2.m_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL keep10_end got=%b want=0", b2.m_valid_o);
        end
        step;
        put2(4'hC, 4'hD, 2'b11, 1'b0, 1'b1);
        #1;
        total++;
        if (b2.m_valid_o !== 1'b0 || b2.s_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL keep00 got=%b/%b want=0/1",
                     b2.m_valid_o, b2.s_ready_o);
        end
        step;
        put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        #1;
        total++;
        if (b2.m_valid_o !== 1'b1 || b2.m_data_o !== 4'hC ||
            b2.m_last_o !== 1'b0) begin
            bad++;
            $display("FAIL keep_next0 got=%b/%h/%b want=1/c/0",
                     b2.m_valid_o, b2.m_data_o, b2.m_last_o);
        end
        step;
        #1;
        total++;
        if (b2.m_valid_o !== 1'b1 || b2.m_data_o !== 4'hD ||
            b2.m_last_o !== 1'b0) begin
            bad++;
            $display("FAIL keep_next1 got=%b/%h/%b want=1/d/0",
                     b2.m_valid_o, b2.m_data_o, b2.m_last_o);
        end
        step;
    endtask

    task automatic test_stall;
        int wi;
        int oi;
        int cyc;
        logic pv;
        logic pr;
        logic [3:0] pd;
        logic pl;
        wi  = 0;
        oi  = 0;
        cyc = 0;
        pv  = 1'b0;
        pr  = 1'b0;
        pd  = 4'h0;
        pl  = 1'b0;
        while (oi < 16 && cyc < 400) begin
            logic [3:0] ed;
            logic el;
            step;
            cyc++;
            if (wi < 8) begin
                put2(4'(2 * wi), 4'(2 * wi + 1), 2'b11, wi % 2 == 1, 1'b1);
            end else begin
                put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
            end
            b2.m_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (pv && !pr) begin
                total++;
                if (b2.m_valid_o !== 1'b1 || b2.m_data_o !== pd ||
                    b2.m_last_o !== pl) begin
                    bad++;
                    $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b",
                             b2.m_valid_o, b2.m_data_o, b2.m_last_o, pd, pl);
                end
            end
            if (b2.m_valid_o === 1'b1 && b2.m_ready_i) begin
                ed = 4'(oi);
                el = (oi % 2 == 1) && ((oi / 2) % 2 == 1);
                total++;
                if (b2.m_data_o !== ed || b2.m_last_o !== el) begin
                    bad++;
                    $display("FAIL stall_beat%0d got=%h/%b want=%h/%b",
                             oi, b2.m_data_o, b2.m_last_o, ed, el);
                end
                oi++;
            end
            if (b2.s_valid_i && b2.s_ready_o === 1'b1) begin
                wi++;
            end
            pv = b2.m_valid_o;
            pr = b2.m_ready_i;
            pd = b2.m_data_o;
            pl = b2.m_last_o;
        end
        total++;
        if (oi != 16) begin
            bad++;
            $display("FAIL stall_count got=%0d want=16", oi);
        end
        b2.m_ready_i = 1'b1;
        put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        step;
        step;
    endtask

    task automatic test_reset_mid;
        b2.m_ready_i = 1'b1;
        step;
        put2(4'hA, 4'hB, 2'b11, 1'b1, 1'b1);
        step;
        put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        #1;
        total++;
        if (b2.m_valid_o !== 1'b1 || b2.m_data_o !== 4'hA) begin
            bad++;
            $display("FAIL rmid_beat0 got=%b/%h want=1/a",
                     b2.m_valid_o, b2.m_data_o);
        end
        step;
        rst_n = 1'b0;
        #1;
        total++;
        if (b2.s_ready_o !== 1'b0 || b2.m_valid_o !== 1'b0 ||
            b2.m_last_o !== 1'b0) begin
            bad++;
            $display("FAIL rmid_in_rst got=%b/%b/%b want=0/0/0",
                     b2.s_ready_o, b2.m_valid_o, b2.m_last_o);
        end
        step;
        rst_n = 1'b1;
        #1;
        total++;
        if (b2.s_ready_o !== 1'b1 || b2.m_data_o !== 4'h0) begin
            bad++;
            $display("FAIL rmid_after got=%b/%h want=1/0",
                     b2.s_ready_o, b2.m_data_o);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (b2.m_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL rmid_ghost%0d got=%b want=0", i, b2.m_valid_o);
            end
            step;
        end
    endtask

    task automatic test_sparse4;
        b4.m_ready_i   = 1'b1;
        step;
        b4.s_data_i[0] = 4'h0;
        b4.s_data_i[1] = 4'h1;
        b4.s_data_i[2] = 4'h2;
        b4.s_data_i[3] = 4'h3;
        b4.s_keep_i    = 4'b0101;
        b4.s_last_i    = 1'b1;
        b4.s_valid_i   = 1'b1;
        step;
        b4.s_valid_i   = 1'b0;
        #1;
        total++;
        if (b4.m_valid_o !== 1'b1 || b4.m_data_o !== 4'h0 ||
            b4.m_last_o !== 1'b0 || b4.s_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL sp4_beat0 got=%b/%h/%b/%b want=1/0/0/0",
                     b4.m_valid_o, b4.m_data_o, b4.m_last_o, b4.s_ready_o);
        end
        step;
        #1;
        total++;
        if (b4.m_valid_o !== 1'b1 || b4.m_data_o !== 4'h2 ||
            b4.m_last_o !== 1'b1 || b4.s_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL sp4_beat2 got=%b/%h/%b/%b want=1/2/1/1",
                     b4.m_valid_o, b4.m_data_o, b4.m_last_o, b4.s_ready_o);
        end
        step;
        #1;
        total++;
        if (b4.m_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL sp4_end got=%b want=0", b4.m_valid_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        put2(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        b2.m_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b4.s_data_i[i] = 4'h0;
        end
        b4.s_keep_i  = 4'b0000;
        b4.s_last_i  = 1'b0;
        b4.s_valid_i = 1'b0;
        b4.m_ready_i = 1'b1;
        test_reset;
        test_single;
        test_back_to_back;
        test_keep;
        test_stall;
        test_reset_mid;
        test_sparse4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_downsize.md
STREAM_DOWNSIZE -- requirements
Module: stream_downsize

Interface
REQ-001 The module SHALL have parameter T_DATA_WIDTH, default 4: width of one narrow output beat, also width of one input lane.
REQ-002 The module SHALL have parameter T_DATA_RATIO, default 2: number of lanes per wide input word, >= 2.
REQ-003 The module SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port s_data_i  input  T_DATA_WIDTH x [T_DATA_RATIO-1:0] unpacked array  wide input word, lane 0 first in time.
REQ-006 The module SHALL have port s_keep_i  input  T_DATA_RATIO  per-lane valid mask of the input word.
REQ-007 The module SHALL have port s_last_i  input  1  input word ends a packet.
REQ-008 The module SHALL have port s_valid_i  input  1  input word valid.
REQ-009 The module SHALL have port s_ready_o  output  1  module accepts the input word.
REQ-010 The module SHALL have port m_data_o  output  T_DATA_WIDTH  narrow output beat.
REQ-011 The module SHALL have port m_last_o  output  1  output beat ends a packet.
REQ-012 The module SHALL have port m_valid_o  output  1  output beat valid.
REQ-013 The module SHALL have port m_ready_i  input  1  downstream accepts the beat.

Function
REQ-014 An input word SHALL be accepted on a posedge where s_valid_i && s_ready_o; an output beat SHALL be transferred on a posedge where m_valid_o && m_ready_i.
REQ-015 The module SHALL hold one wide word in registers: data_q, pending-lane mask rem_q (T_DATA_RATIO bits) and last_q.
REQ-016 The FSM SHALL have two states: IDLE (rem_q empty) and SEND (rem_q non-zero).
REQ-017 In IDLE: s_ready_o=1, m_valid_o=0.
REQ-018 In SEND: m_valid_o=1; current lane = lowest set bit index of rem_q; m_data_o = data_q[current lane].
REQ-019 m_last_o SHALL be last_q && (rem_q has exactly one bit set); otherwise 0.
REQ-020 On an output transfer, the current lane bit SHALL be cleared in rem_q.
REQ-021 In SEND, s_ready_o SHALL be m_ready_i && (rem_q has exactly one bit set), so back-to-back words stream with no bubble; this path is combinational from m_ready_i.
REQ-022 On acceptance: data_q<=s_data_i, rem_q<=s_keep_i, last_q<=s_last_i.
REQ-023 The state SHALL be SEND if s_keep_i!=0, else IDLE.
REQ-024 Acceptance and the final-lane transfer in the same cycle SHALL load the new word; the clear of the old lane SHALL be overridden.
REQ-025 Latency: the first beat of an accepted word SHALL appear on m_valid_o the cycle after acceptance.
REQ-026 Kept lanes SHALL be emitted in ascending index order; unkept lanes SHALL be skipped with no idle cycle between kept lanes.
REQ-027 Non-contiguous keep (e.g. 4'b0101) SHALL be legal and emit lanes 0 and 2 only.
REQ-028 A word with s_keep_i==0 SHALL be accepted and discarded with no output beat, including its s_last_i.
REQ-029 While m_valid_o && !m_ready_i, m_data_o and m_last_o SHALL remain stable.
REQ-030 Once asserted, m_valid_o SHALL not deassert until transfer.
REQ-031 s_data_i/s_keep_i/s_last_i SHALL be ignored when s_valid_i=0 or s_ready_o=0.
REQ-032 Throughput: one beat per cycle while m_ready_i=1; a full word of T_DATA_RATIO lanes SHALL take exactly T_DATA_RATIO cycles.

Reset
REQ-033 While rst_n=0 at a posedge: rem_q<=0, last_q<=0, data_q<=0, state<=IDLE.
REQ-034 While rst_n=0, m_valid_o=0, m_last_o=0 and s_ready_o=0 (gated by rst_n).
REQ-035 m_data_o SHALL be 0 after reset.
REQ-036 Reset asserted in SEND SHALL discard the held word; no beat of it SHALL appear after reset.
REQ-037 s_ready_o SHALL be 1 in the first cycle after rst_n rises.

Verification (T_DATA_WIDTH=4, T_DATA_RATIO=2 unless stated)
REQ-038 Single word {A,B}, keep=2'b11, last=1, m_ready_i=1 -> beats A (last=0), B (last=1) on consecutive cycles starting 1 cycle after acceptance.
REQ-039 Words {1,2},{3,4},{5,6}, keep=11, s_valid_i held -> output 1..6 with no gap; s_ready_o high in every B-beat cycle.
REQ-040 keep=2'b10, data {A,B}, last=1 -> single beat B with m_last_o=1; keep=2'b00, last=1 -> no beat, next word accepted normally.
REQ-041 m_ready_i toggled randomly 50% with continuous input -> no lost or duplicated beats; data/last stable during stall; order preserved.
REQ-042 rst_n pulsed low for 1 cycle after the first beat of {A,B} -> B never appears; s_ready_o=0 during reset, 1 the cycle after.
REQ-043 T_DATA_RATIO=4, keep=4'b0101, data {0,1,2,3}, last=1 -> beats 0 then 2; m_last_o on beat 2.
